// File: rtl/pool_pkg.sv
// Shared definitions for the pool table logic: default geometry, index-width
// helpers, the flattened-bus slice convention and the scanner state encoding.
package pool_pkg;

    // Default signed coordinate width used by the table physics.
    localparam int DEF_COORD_W   = 11;
    // Default capture threshold on squared ball-to-pocket distance (inclusive).
    localparam int DEF_RADIUS_SQ = 1023;

    // Width of an index selecting one of n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter able to hold the values 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Flattened buses pack item i at [i*w +: w]; this returns that low bit.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_e;

endpackage

// File: rtl/dist_sq_pipe.sv
// Two-stage squared-distance pipeline: stage 1 forms widened coordinate
// differences, stage 2 forms dx*dx + dy*dy. A valid bit and the (ball, pocket)
// tag travel alongside the data so the consumer knows which pair it sees.
module dist_sq_pipe #(
    parameter int COORD_W = 11,
    parameter int BW      = 4,
    parameter int PW      = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [COORD_W-1:0]         in_bx,
    input  logic [COORD_W-1:0]         in_by,
    input  logic [COORD_W-1:0]         in_px,
    input  logic [COORD_W-1:0]         in_py,
    input  logic [BW-1:0]              in_ball,
    input  logic [PW-1:0]              in_pocket,
    output logic                       out_valid,
    output logic [2*(COORD_W+1):0]     out_sum,
    output logic [BW-1:0]              out_ball,
    output logic [PW-1:0]              out_pocket
);

    localparam int DW    = COORD_W + 1;
    localparam int SUM_W = 2 * DW + 1;

    logic                   s1_valid_q, s1_valid_d;
    logic signed [DW-1:0]   dx_q, dx_d;
    logic signed [DW-1:0]   dy_q, dy_d;
    logic [BW-1:0]          s1_ball_q, s1_ball_d;
    logic [PW-1:0]          s1_pocket_q, s1_pocket_d;

    logic                   s2_valid_q, s2_valid_d;
    logic [SUM_W-1:0]       sum_q, sum_d;
    logic [BW-1:0]          s2_ball_q, s2_ball_d;
    logic [PW-1:0]          s2_pocket_q, s2_pocket_d;

    logic signed [2*DW-1:0] sq_x_s;
    logic signed [2*DW-1:0] sq_y_s;

    // Stage 1: sign-extend by one bit before subtracting so opposite corners never wrap.
    always_comb begin
        s1_valid_d  = in_valid;
        dx_d        = {in_px[COORD_W-1], in_px} - {in_bx[COORD_W-1], in_bx};
        dy_d        = {in_py[COORD_W-1], in_py} - {in_by[COORD_W-1], in_by};
        s1_ball_d   = in_ball;
        s1_pocket_d = in_pocket;
    end

    // Stage 2: squares are non-negative, so the sum is carried as unsigned.
    always_comb begin
        sq_x_s      = dx_q * dx_q;
        sq_y_s      = dy_q * dy_q;
        s2_valid_d  = s1_valid_q;
        sum_d       = {1'b0, sq_x_s} + {1'b0, sq_y_s};
        s2_ball_d   = s1_ball_q;
        s2_pocket_d = s1_pocket_q;
    end

    // Pipeline registers for both stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            dx_q        <= '0;
            dy_q        <= '0;
            s1_ball_q   <= '0;
            s1_pocket_q <= '0;
            s2_valid_q  <= 1'b0;
            sum_q       <= '0;
            s2_ball_q   <= '0;
            s2_pocket_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            s1_ball_q   <= s1_ball_d;
            s1_pocket_q <= s1_pocket_d;
            s2_valid_q  <= s2_valid_d;
            sum_q       <= sum_d;
            s2_ball_q   <= s2_ball_d;
            s2_pocket_q <= s2_pocket_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_sum    = sum_q;
    assign out_ball   = s2_ball_q;
    assign out_pocket = s2_pocket_q;

endmodule

// File: rtl/pocket_scanner.sv
// Time-multiplexed pocket test. Each frame start snapshots all ball and pocket
// coordinates, then walks every (ball, pocket) pair, one per clock, through the
// squared-distance pipeline. The final compare stage maintains sticky potted
// flags, a potted count and a one-shot event for each newly potted ball.
module pocket_scanner
    import pool_pkg::*;
#(
    parameter int NUM_BALLS   = 16,
    parameter int NUM_POCKETS = 6,
    parameter int COORD_W     = DEF_COORD_W,
    parameter int RADIUS_SQ   = DEF_RADIUS_SQ
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic                                 clear_potted,
    input  logic [NUM_BALLS*COORD_W-1:0]         ball_x,
    input  logic [NUM_BALLS*COORD_W-1:0]         ball_y,
    input  logic [NUM_BALLS-1:0]                 ball_active,
    input  logic [NUM_POCKETS*COORD_W-1:0]       pocket_x,
    input  logic [NUM_POCKETS*COORD_W-1:0]       pocket_y,
    output logic [NUM_BALLS-1:0]                 potted,
    output logic                                 pot_valid,
    output logic [idx_w(NUM_BALLS)-1:0]          pot_ball,
    output logic [idx_w(NUM_POCKETS)-1:0]        pot_pocket,
    output logic [cnt_w(NUM_BALLS)-1:0]          pot_count,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 overrun
);

    localparam int BW    = idx_w(NUM_BALLS);
    localparam int PW    = idx_w(NUM_POCKETS);
    localparam int CW    = cnt_w(NUM_BALLS);
    localparam int SUM_W = 2 * (COORD_W + 1) + 1;
    localparam logic [SUM_W-1:0] RAD_SQ      = SUM_W'(RADIUS_SQ);
    localparam logic [BW-1:0]    LAST_BALL   = BW'(NUM_BALLS - 1);
    localparam logic [PW-1:0]    LAST_POCKET = PW'(NUM_POCKETS - 1);

    scan_state_e                     state_q, state_d;
    logic [BW-1:0]                   ball_q, ball_d;
    logic [PW-1:0]                   pocket_q, pocket_d;
    logic [NUM_BALLS*COORD_W-1:0]    snap_bx_q, snap_bx_d;
    logic [NUM_BALLS*COORD_W-1:0]    snap_by_q, snap_by_d;
    logic [NUM_BALLS-1:0]            snap_act_q, snap_act_d;
    logic [NUM_POCKETS*COORD_W-1:0]  snap_px_q, snap_px_d;
    logic [NUM_POCKETS*COORD_W-1:0]  snap_py_q, snap_py_d;
    logic [NUM_BALLS-1:0]            potted_q, potted_d;
    logic [CW-1:0]                   pot_count_q, pot_count_d;
    logic                            pot_valid_q, pot_valid_d;
    logic [BW-1:0]                   pot_ball_q, pot_ball_d;
    logic [PW-1:0]                   pot_pocket_q, pot_pocket_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            overrun_q, overrun_d;

    logic                            issue_valid_s;
    logic [COORD_W-1:0]              issue_bx_s, issue_by_s, issue_px_s, issue_py_s;
    logic                            last_issue_s;
    logic                            cmp_valid_s;
    logic [SUM_W-1:0]                cmp_sum_s;
    logic [BW-1:0]                   cmp_ball_s;
    logic [PW-1:0]                   cmp_pocket_s;
    logic                            last_cmp_s;
    logic                            hit_s;

    // Select the current pair's coordinates from the snapshot.
    always_comb begin
        issue_valid_s = (state_q == ST_SCAN);
        issue_bx_s    = snap_bx_q[slice_lo(int'(ball_q), COORD_W) +: COORD_W];
        issue_by_s    = snap_by_q[slice_lo(int'(ball_q), COORD_W) +: COORD_W];
        issue_px_s    = snap_px_q[slice_lo(int'(pocket_q), COORD_W) +: COORD_W];
        issue_py_s    = snap_py_q[slice_lo(int'(pocket_q), COORD_W) +: COORD_W];
        last_issue_s  = (ball_q == LAST_BALL) && (pocket_q == LAST_POCKET);
        last_cmp_s    = cmp_valid_s && (cmp_ball_s == LAST_BALL) && (cmp_pocket_s == LAST_POCKET);
    end

    dist_sq_pipe #(
        .COORD_W (COORD_W),
        .BW      (BW),
        .PW      (PW)
    ) u_dist (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (issue_valid_s),
        .in_bx      (issue_bx_s),
        .in_by      (issue_by_s),
        .in_px      (issue_px_s),
        .in_py      (issue_py_s),
        .in_ball    (ball_q),
        .in_pocket  (pocket_q),
        .out_valid  (cmp_valid_s),
        .out_sum    (cmp_sum_s),
        .out_ball   (cmp_ball_s),
        .out_pocket (cmp_pocket_s)
    );

    // Next-state logic: drain ends on the edge that compares the final pair.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SCAN;
                else       state_d = ST_IDLE;
            end
            ST_SCAN: begin
                if (last_issue_s) state_d = ST_DRAIN;
                else              state_d = ST_SCAN;
            end
            ST_DRAIN: begin
                if (last_cmp_s) state_d = ST_IDLE;
                else            state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Snapshot capture at frame start and pair walk with pocket index fastest.
    always_comb begin
        ball_d     = ball_q;
        pocket_d   = pocket_q;
        snap_bx_d  = snap_bx_q;
        snap_by_d  = snap_by_q;
        snap_act_d = snap_act_q;
        snap_px_d  = snap_px_q;
        snap_py_d  = snap_py_q;
        if ((state_q == ST_IDLE) && start) begin
            snap_bx_d  = ball_x;
            snap_by_d  = ball_y;
            snap_act_d = ball_active;
            snap_px_d  = pocket_x;
            snap_py_d  = pocket_y;
            ball_d     = '0;
            pocket_d   = '0;
        end else if (state_q == ST_SCAN) begin
            if (last_issue_s) begin
                ball_d   = '0;
                pocket_d = '0;
            end else if (pocket_q == LAST_POCKET) begin
                ball_d   = ball_q + BW'(1);
                pocket_d = '0;
            end else begin
                pocket_d = pocket_q + PW'(1);
            end
        end else begin
            ball_d   = ball_q;
            pocket_d = pocket_q;
        end
    end

    // Compare stage: a clear wins over a same-cycle hit; flags already set suppress repeats.
    always_comb begin
        hit_s        = cmp_valid_s && (cmp_sum_s <= RAD_SQ) &&
                       snap_act_q[cmp_ball_s] && !potted_q[cmp_ball_s];
        potted_d     = potted_q;
        pot_count_d  = pot_count_q;
        pot_valid_d  = 1'b0;
        pot_ball_d   = pot_ball_q;
        pot_pocket_d = pot_pocket_q;
        if (clear_potted) begin
            potted_d    = '0;
            pot_count_d = '0;
        end else if (hit_s) begin
            potted_d[cmp_ball_s] = 1'b1;
            pot_count_d          = pot_count_q + CW'(1);
            pot_valid_d          = 1'b1;
            pot_ball_d           = cmp_ball_s;
            pot_pocket_d         = cmp_pocket_s;
        end else begin
            pot_valid_d = 1'b0;
        end
    end

    // Status outputs, registered so they align with the state they describe.
    always_comb begin
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_q == ST_DRAIN) && (state_d == ST_IDLE);
        overrun_d = start && (state_q != ST_IDLE);
    end

    // State, snapshot, counters and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ball_q       <= '0;
            pocket_q     <= '0;
            snap_bx_q    <= '0;
            snap_by_q    <= '0;
            snap_act_q   <= '0;
            snap_px_q    <= '0;
            snap_py_q    <= '0;
            potted_q     <= '0;
            pot_count_q  <= '0;
            pot_valid_q  <= 1'b0;
            pot_ball_q   <= '0;
            pot_pocket_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ball_q       <= ball_d;
            pocket_q     <= pocket_d;
            snap_bx_q    <= snap_bx_d;
            snap_by_q    <= snap_by_d;
            snap_act_q   <= snap_act_d;
            snap_px_q    <= snap_px_d;
            snap_py_q    <= snap_py_d;
            potted_q     <= potted_d;
            pot_count_q  <= pot_count_d;
            pot_valid_q  <= pot_valid_d;
            pot_ball_q   <= pot_ball_d;
            pot_pocket_q <= pot_pocket_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign potted     = potted_q;
    assign pot_valid  = pot_valid_q;
    assign pot_ball   = pot_ball_q;
    assign pot_pocket = pot_pocket_q;
    assign pot_count  = pot_count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pocket_scanner.sv
// Directed bench for pocket_scanner with 4 balls and 2 pockets.
module tb_pocket_scanner;

    localparam int NB = 4;
    localparam int NP = 2;
    localparam int CW = 11;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             clear_potted;
    logic [NB*CW-1:0] ball_x;
    logic [NB*CW-1:0] ball_y;
    logic [NB-1:0]    ball_active;
    logic [NP*CW-1:0] pocket_x;
    logic [NP*CW-1:0] pocket_y;
    logic [NB-1:0]    potted;
    logic             pot_valid;
    logic [1:0]       pot_ball;
    logic [0:0]       pot_pocket;
    logic [2:0]       pot_count;
    logic             busy;
    logic             done;
    logic             overrun;

    int checks   = 0;
    int failures = 0;

    int ev_cnt   = 0;
    int ev_ball  = -1;
    int ev_pock  = -1;
    int done_cnt = 0;
    int ov_cnt   = 0;

    int lat;
    int ev_base;
    int done_base;
    int ov_base;

    pocket_scanner #(
        .NUM_BALLS   (NB),
        .NUM_POCKETS (NP),
        .COORD_W     (CW),
        .RADIUS_SQ   (1023)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .clear_potted (clear_potted),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .ball_active  (ball_active),
        .pocket_x     (pocket_x),
        .pocket_y     (pocket_y),
        .potted       (potted),
        .pot_valid    (pot_valid),
        .pot_ball     (pot_ball),
        .pot_pocket   (pot_pocket),
        .pot_count    (pot_count),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor sampling on the falling edge.
    always @(negedge clk) begin
        if (pot_valid === 1'b1) begin
            ev_cnt  = ev_cnt + 1;
            ev_ball = int'(pot_ball);
            ev_pock = int'(pot_pocket);
        end
        if (done === 1'b1)    done_cnt = done_cnt + 1;
        if (overrun === 1'b1) ov_cnt   = ov_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_ball(input int i, input int x, input int y, input logic act);
        logic [31:0] xv;
        logic [31:0] yv;
        xv = x;
        yv = y;
        ball_x[i*CW +: CW] = xv[CW-1:0];
        ball_y[i*CW +: CW] = yv[CW-1:0];
        ball_active[i]     = act;
    endtask

    task automatic set_pocket(input int i, input int x, input int y);
        logic [31:0] xv;
        logic [31:0] yv;
        xv = x;
        yv = y;
        pocket_x[i*CW +: CW] = xv[CW-1:0];
        pocket_y[i*CW +: CW] = yv[CW-1:0];
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Pulse start, return edges from the start edge to done (-1 on timeout).
    task automatic run_frame(output int l);
        l = -1;
        ev_base   = ev_cnt;
        done_base = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                l = n;
                break;
            end
        end
        settle();
    endtask

    task automatic wait_done(output int l);
        l = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                l = n;
                break;
            end
        end
        settle();
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_potted = 1'b1;
        @(negedge clk);
        clear_potted = 1'b0;
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        clear_potted = 1'b0;
        ball_x       = '0;
        ball_y       = '0;
        ball_active  = '0;
        pocket_x     = '0;
        pocket_y     = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_potted", 32'(potted), 32'd0);
        check("reset_count", 32'(pot_count), 32'd0);
        check("reset_flags", {28'd0, pot_valid, busy, done, overrun}, 32'd0);
        check("reset_idx", {29'd0, pot_ball, pot_pocket}, 32'd0);
        reset_n = 1'b1;
        settle();

        // Frame 1: only ball2 within reach of pocket 0.
        set_pocket(0, 0, 0);
        set_pocket(1, 600, 0);
        set_ball(0, 300, 300, 1'b1);
        set_ball(1, -500, 500, 1'b1);
        set_ball(2, 20, 20, 1'b1);
        set_ball(3, 0, -600, 1'b1);
        run_frame(lat);
        check("f1_latency", 32'(lat), 32'd10);
        check("f1_events", 32'(ev_cnt - ev_base), 32'd1);
        check("f1_ev_ball", 32'(ev_ball), 32'd2);
        check("f1_ev_pocket", 32'(ev_pock), 32'd0);
        check("f1_potted", 32'(potted), 32'b0100);
        check("f1_count", 32'(pot_count), 32'd1);
        check("f1_busy", 32'(busy), 32'd0);

        // Frame 2: same table, ball already potted.
        run_frame(lat);
        check("f2_latency", 32'(lat), 32'd10);
        check("f2_events", 32'(ev_cnt - ev_base), 32'd0);
        check("f2_potted", 32'(potted), 32'b0100);
        check("f2_done", 32'(done_cnt - done_base), 32'd1);

        // Frame 3: inclusive radius boundary.
        do_clear();
        check("clr_potted", 32'(potted), 32'd0);
        check("clr_count", 32'(pot_count), 32'd0);
        set_ball(0, 31, 0, 1'b1);
        set_ball(1, 32, 0, 1'b1);
        set_ball(2, 300, -300, 1'b1);
        run_frame(lat);
        check("f3_events", 32'(ev_cnt - ev_base), 32'd1);
        check("f3_ev_ball", 32'(ev_ball), 32'd0);
        check("f3_potted", 32'(potted), 32'b0001);
        check("f3_count", 32'(pot_count), 32'd1);

        // Frame 4: one ball in range of both pockets.
        do_clear();
        set_pocket(0, 0, 0);
        set_pocket(1, 10, 0);
        set_ball(0, 300, 300, 1'b1);
        set_ball(1, -500, 500, 1'b1);
        set_ball(2, 300, -300, 1'b1);
        set_ball(3, 5, 0, 1'b1);
        run_frame(lat);
        check("f4_events", 32'(ev_cnt - ev_base), 32'd1);
        check("f4_ev_ball", 32'(ev_ball), 32'd3);
        check("f4_ev_pocket", 32'(ev_pock), 32'd0);
        check("f4_potted", 32'(potted), 32'b1000);

        // Frame 5: far corners must not wrap; inactive ball on a pocket centre.
        do_clear();
        set_pocket(0, 1000, 1000);
        set_pocket(1, 1023, 1023);
        set_ball(0, -1000, -1000, 1'b1);
        set_ball(1, -1024, -1024, 1'b1);
        set_ball(2, 1000, 1000, 1'b0);
        set_ball(3, 0, 0, 1'b1);
        run_frame(lat);
        check("f5_events", 32'(ev_cnt - ev_base), 32'd0);
        check("f5_potted", 32'(potted), 32'd0);
        check("f5_count", 32'(pot_count), 32'd0);

        // Frame 6: start repeated three cycles into the scan.
        set_pocket(0, 0, 0);
        set_pocket(1, 600, 0);
        set_ball(0, 300, 300, 1'b1);
        set_ball(1, -500, 500, 1'b1);
        set_ball(2, 20, 20, 1'b1);
        set_ball(3, 0, -600, 1'b1);
        ev_base   = ev_cnt;
        done_base = done_cnt;
        ov_base   = ov_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        check("f6_busy_mid", 32'(busy), 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        check("f6_latency_after_overrun", 32'(lat), 32'd7);
        repeat (5) @(negedge clk);
        #1;
        check("f6_overrun", 32'(ov_cnt - ov_base), 32'd1);
        check("f6_done_once", 32'(done_cnt - done_base), 32'd1);
        check("f6_events", 32'(ev_cnt - ev_base), 32'd1);
        check("f6_potted", 32'(potted), 32'b0100);

        // Frame 7: clear coincides with ball2's hit on pocket 0 (pair 4, edge E0+7).
        do_clear();
        ev_base = ev_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 clear_potted = 1'b1;
        @(posedge clk);
        #1 clear_potted = 1'b0;
        wait_done(lat);
        check("f7_latency", 32'(lat), 32'd3);
        check("f7_events", 32'(ev_cnt - ev_base), 32'd0);
        check("f7_potted", 32'(potted), 32'd0);
        check("f7_count", 32'(pot_count), 32'd0);

        // Frame 8: two balls potted in one frame.
        set_ball(0, 31, 0, 1'b1);
        run_frame(lat);
        check("f8_events", 32'(ev_cnt - ev_base), 32'd2);
        check("f8_potted", 32'(potted), 32'b0101);
        check("f8_count", 32'(pot_count), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
